turf_udp_port_switch: RTL and testbench
=======================================

# turf_udp_port_switch

Parametrised UDP port switch sitting between the TURF UDP core and the per-service logic. It demultiplexes received UDP header+payload streams to one of NUM_PORTS channels by destination port, and dropping unmatched packets with a count. It arbitrates NUM_PORTS transmit channels round-robin onto the single core transmit stream, inserting each channel's fixed source port. Both directions are packet-atomic: a channel owns the path from header handshake to payload tlast.

## Interface
- NUM_PORTS, 4: number of channels, 1–16.
- PORT_LIST, {16'd21603,16'd21602,16'd21601,16'd21600}: packed NUM_PORTS×16; channel k owns bits [16k +: 16]; used for RX match and TX source port.
- clk  in  1  logic clock, shared with the UDP core.
- rst_n  in  1  synchronous, active-low reset.
- s_rxhdr_tdata/tvalid/tready  in/in/out  64/1/1  from core: [63:32] src IP, [31:16] src port, [15:0] length.
- s_rxhdr_tdest  in  16  destination port.
- s_rxdata_tdata/tkeep/tlast/tvalid/tready  in/in/in/in/out  64/8/1/1/1  RX payload from core.
- m_rxhdr_tdata/tvalid/tready  out/out/in  NUM_PORTS×64/NUM_PORTS/NUM_PORTS  per-channel RX header; same field layout.
- m_rxdata_tdata/tkeep/tlast/tvalid/tready  out/out/out/out/in  NUM_PORTS×(64/8/1/1/1)  per-channel RX payload.
- s_txhdr_tdata/tvalid/tready  in/in/out  NUM_PORTS×64/NUM_PORTS/NUM_PORTS  per-channel TX header: [63:32] dst IP, [31:16] dst port, [15:0] length.
- s_txdata_tdata/tkeep/tlast/tvalid/tready  in/in/in/in/out  NUM_PORTS×(64/8/1/1/1)  per-channel TX payload.
- m_txhdr_tdata/tvalid/tready  out/out/in  64/1/1  to core, layout as s_txhdr.
- m_txhdr_tuser  out  16  source port = PORT_LIST entry of granted channel.
- m_txdata_tdata/tkeep/tlast/tvalid/tready  out/out/out/out/in  64/8/1/1/1  TX payload to core.
- rx_drop_count  out  32  unmatched RX packets, saturating.

## Operation
- RX FSM: R_IDLE, R_HDR, R_DATA, R_DROP.
- R_IDLE: s_rxhdr_tready=1. On handshake, register tdata and the match index (lowest k with PORT_LIST[k]==tdest). If matched, go to R_HDR; otherwise go to R_DROP and increment rx_drop_count, saturating at 2^32−1.
- R_HDR: m_rxhdr_tvalid[k]=1 with the registered tdata until the channel's tready. Then go to R_DATA.
- R_DATA: channel k payload is a combinational pass-through: m_rxdata_*[k] follows s_rxdata_*, and s_rxdata_tready follows m_rxdata_tready[k]. All other channels have tvalid=0. Go to R_IDLE on an accepted tlast beat.
- R_DROP: s_rxdata_tready=1. Discard beats until tlast is accepted, then go to R_IDLE.
- TX FSM: T_IDLE, T_HDR, T_DATA.
- T_IDLE: if any s_txhdr_tvalid is set, grant the first requester searching from last_grant+1 modulo NUM_PORTS. Register grant, header, and source port, and pulse s_txhdr_tready[grant] in the same cycle. Go to T_HDR.
- T_HDR: m_txhdr_tvalid=1 until m_txhdr_tready. Then go to T_DATA.
- T_DATA: pass through s_txdata_*[grant] to m_txdata_*. Go to T_IDLE on an accepted tlast beat, updating last_grant to grant.
- Payload tready for non-granted or non-data states is 0 in both directions. The RX and TX paths are fully independent.

## Timing
- Reset: every tvalid and tready output is 0, rx_drop_count=0, both FSMs are idle, last_grant=NUM_PORTS−1 (so channel 0 has first priority). All data outputs are 0.
- RX header latency: 1 cycle from input handshake to m_rxhdr_tvalid. The earliest payload beat transfers in the cycle after the output header handshake.
- TX header latency: 1 cycle from input handshake to m_txhdr_tvalid.
- Payload paths add no latency and no bubbles. The minimum packet overhead is 2 cycles per direction.
- A single-beat packet (tlast on the first beat) returns to idle in the next cycle.
- A request raised while the TX path is busy waits; a new grant is only made in T_IDLE.
- Reset mid-packet aborts immediately. Any partial packet is truncated, and surrounding logic is reset together.
- Duplicate PORT_LIST entries: the lowest index wins for RX.

## Structure
- Package turf_udp_pkg holds:
  - RX and TX state encodings.
  - Header field constants: IP_LSB=32, PORT_LSB=16, LEN_LSB=0.
  - The port_lookup function, which returns a match flag and an index.
- Sub-module turf_rr_arbiter holds the NUM_PORTS-wide round-robin grant with last_grant state. It is reusable for later event-stream muxes.

## Test plan
- RX match: tdest=21602 with a 3-beat payload → channel 2 gets the header 1 cycle later and exactly 3 beats with tlast on beat 3. Other channels stay idle.
- RX drop: tdest=9999 with a 5-beat payload → all 5 beats consumed, no channel tvalid, rx_drop_count 0→1. A following tdest=21600 packet routes to channel 0.
- TX round-robin: channels 0, 1, 3 all request continuously → grant order 0,1,3,0,1,3. m_txhdr_tuser is 21600, 21601, 21603 respectively.
- Backpressure: random tready deassertion on m_rxdata[1] and m_txdata → no beat lost, duplicated or reordered, and tkeep is preserved.
- Reset mid-packet: rst_n low during beat 2 of a 4-beat RX packet → all outputs are 0 the next cycle. After release, a new packet routes correctly.
- Saturation: preload rx_drop_count to 0xFFFF_FFFF via a force, then send one unmatched packet → the count stays 0xFFFF_FFFF.

Source files
------------

// File: rtl/turf_udp_pkg.sv
// turf_udp_pkg: shared state encodings, header field offsets and port lookup for the TURF UDP switch.
package turf_udp_pkg;

    typedef enum logic [1:0] {R_IDLE, R_HDR, R_DATA, R_DROP} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_HDR, T_DATA} tx_state_t;

    localparam int IP_LSB   = 32;
    localparam int PORT_LSB = 16;
    localparam int LEN_LSB  = 0;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } port_match_t;

    // Scans downward so the lowest matching index is the one that sticks.
    function automatic port_match_t port_lookup(input logic [255:0] list, input int n,
                                                input logic [15:0] port);
        port_match_t m;
        m = '0;
        for (int k = 15; k >= 0; k--) begin
            if (k < n && list[16*k +: 16] == port) begin
                m.hit = 1'b1;
                m.idx = 4'(k);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/turf_rr_arbiter.sv
// turf_rr_arbiter: N-way round-robin grant, searching upward from the channel after last_grant.
module turf_rr_arbiter #(
    parameter int N = 4,
    localparam int IW = N > 1 ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          update,
    input  logic [IW-1:0] update_idx,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] last_grant;

    always_ff @(posedge clk) begin
        if (!rst_n)
            last_grant <= IW'(N - 1);
        else if (update)
            last_grant <= update_idx;
    end

    // Wrap region first, then the region above last_grant overrides it.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = last_grant;
        for (int j = N - 1; j >= 0; j--) begin
            if (req[j] && IW'(j) <= last_grant) begin
                gnt_valid = 1'b1;
                gnt_idx   = IW'(j);
            end
        end
        for (int j = N - 1; j >= 0; j--) begin
            if (req[j] && IW'(j) > last_grant) begin
                gnt_valid = 1'b1;
                gnt_idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/turf_udp_port_switch.sv
// turf_udp_port_switch: demuxes RX UDP packets by destination port and round-robins
// TX channels onto the core, each direction packet-atomic.
module turf_udp_port_switch
    import turf_udp_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter logic [NUM_PORTS*16-1:0] PORT_LIST = {16'd21603, 16'd21602, 16'd21601, 16'd21600}
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [63:0]            s_rxhdr_tdata,
    input  logic                   s_rxhdr_tvalid,
    output logic                   s_rxhdr_tready,
    input  logic [15:0]            s_rxhdr_tdest,
    input  logic [63:0]            s_rxdata_tdata,
    input  logic [7:0]             s_rxdata_tkeep,
    input  logic                   s_rxdata_tlast,
    input  logic                   s_rxdata_tvalid,
    output logic                   s_rxdata_tready,
    output logic [NUM_PORTS*64-1:0] m_rxhdr_tdata,
    output logic [NUM_PORTS-1:0]   m_rxhdr_tvalid,
    input  logic [NUM_PORTS-1:0]   m_rxhdr_tready,
    output logic [NUM_PORTS*64-1:0] m_rxdata_tdata,
    output logic [NUM_PORTS*8-1:0] m_rxdata_tkeep,
    output logic [NUM_PORTS-1:0]   m_rxdata_tlast,
    output logic [NUM_PORTS-1:0]   m_rxdata_tvalid,
    input  logic [NUM_PORTS-1:0]   m_rxdata_tready,
    input  logic [NUM_PORTS*64-1:0] s_txhdr_tdata,
    input  logic [NUM_PORTS-1:0]   s_txhdr_tvalid,
    output logic [NUM_PORTS-1:0]   s_txhdr_tready,
    input  logic [NUM_PORTS*64-1:0] s_txdata_tdata,
    input  logic [NUM_PORTS*8-1:0] s_txdata_tkeep,
    input  logic [NUM_PORTS-1:0]   s_txdata_tlast,
    input  logic [NUM_PORTS-1:0]   s_txdata_tvalid,
    output logic [NUM_PORTS-1:0]   s_txdata_tready,
    output logic [63:0]            m_txhdr_tdata,
    output logic                   m_txhdr_tvalid,
    input  logic                   m_txhdr_tready,
    output logic [15:0]            m_txhdr_tuser,
    output logic [63:0]            m_txdata_tdata,
    output logic [7:0]             m_txdata_tkeep,
    output logic                   m_txdata_tlast,
    output logic                   m_txdata_tvalid,
    input  logic                   m_txdata_tready,
    output logic [31:0]            rx_drop_count
);

    localparam int IW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;

    rx_state_t     rx_state;
    logic [63:0]   rx_hdr;
    logic [IW-1:0] rx_idx;
    port_match_t   rx_match;

    assign rx_match = port_lookup(256'(PORT_LIST), NUM_PORTS, s_rxhdr_tdest);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state      <= R_IDLE;
            rx_hdr        <= '0;
            rx_idx        <= '0;
            rx_drop_count <= '0;
        end else begin
            case (rx_state)
                R_IDLE: if (s_rxhdr_tvalid) begin
                    rx_hdr   <= s_rxhdr_tdata;
                    rx_idx   <= IW'(rx_match.idx);
                    rx_state <= rx_match.hit ? R_HDR : R_DROP;
                    if (!rx_match.hit && rx_drop_count != '1)
                        rx_drop_count <= rx_drop_count + 32'd1;
                end
                R_HDR: if (m_rxhdr_tready[rx_idx]) rx_state <= R_DATA;
                R_DATA, R_DROP: if (s_rxdata_tvalid && s_rxdata_tready && s_rxdata_tlast) rx_state <= R_IDLE;
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    // Header ready is held low while in reset so nothing looks accepted.
    assign s_rxhdr_tready  = rst_n && rx_state == R_IDLE;
    assign s_rxdata_tready = rx_state == R_DROP || (rx_state == R_DATA && m_rxdata_tready[rx_idx]);
    assign m_rxhdr_tdata   = {NUM_PORTS{rx_hdr}};

    tx_state_t     tx_state;
    logic [IW-1:0] tx_grant;
    logic [IW-1:0] arb_idx;
    logic          arb_valid;
    logic          tx_done;
    logic [63:0]   tx_hdr;
    logic [15:0]   tx_sport;

    assign tx_done = tx_state == T_DATA && m_txdata_tvalid && m_txdata_tready && m_txdata_tlast;

    turf_rr_arbiter #(.N(NUM_PORTS)) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (s_txhdr_tvalid),
        .update     (tx_done),
        .update_idx (tx_grant),
        .gnt_valid  (arb_valid),
        .gnt_idx    (arb_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state <= T_IDLE;
            tx_grant <= '0;
            tx_hdr   <= '0;
            tx_sport <= '0;
        end else begin
            case (tx_state)
                T_IDLE: if (arb_valid) begin
                    tx_grant <= arb_idx;
                    tx_hdr   <= s_txhdr_tdata[arb_idx*64 +: 64];
                    tx_sport <= PORT_LIST[arb_idx*16 +: 16];
                    tx_state <= T_HDR;
                end
                T_HDR: if (m_txhdr_tready) tx_state <= T_DATA;
                T_DATA: if (tx_done) tx_state <= T_IDLE;
                default: tx_state <= T_IDLE;
            endcase
        end
    end

    assign m_txhdr_tvalid  = tx_state == T_HDR;
    assign m_txhdr_tdata   = tx_hdr;
    assign m_txhdr_tuser   = tx_sport;
    assign m_txdata_tvalid = tx_state == T_DATA && s_txdata_tvalid[tx_grant];
    assign m_txdata_tlast  = tx_state == T_DATA && s_txdata_tlast[tx_grant];
    assign m_txdata_tdata  = tx_state == T_DATA ? s_txdata_tdata[tx_grant*64 +: 64] : '0;
    assign m_txdata_tkeep  = tx_state == T_DATA ? s_txdata_tkeep[tx_grant*8 +: 8] : '0;

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_ch
        logic rx_sel;
        assign rx_sel                      = rx_state == R_DATA && rx_idx == IW'(k);
        assign m_rxhdr_tvalid[k]           = rx_state == R_HDR && rx_idx == IW'(k);
        assign m_rxdata_tvalid[k]          = rx_sel && s_rxdata_tvalid;
        assign m_rxdata_tlast[k]           = rx_sel && s_rxdata_tlast;
        assign m_rxdata_tdata[64*k +: 64]  = rx_sel ? s_rxdata_tdata : '0;
        assign m_rxdata_tkeep[8*k +: 8]    = rx_sel ? s_rxdata_tkeep : '0;
        assign s_txhdr_tready[k]           = rst_n && tx_state == T_IDLE && arb_valid && arb_idx == IW'(k);
        assign s_txdata_tready[k]          = tx_state == T_DATA && tx_grant == IW'(k) && m_txdata_tready;
    end

endmodule

// File: tb/tb_turf_udp_port_switch.sv
// tb_turf_udp_port_switch: directed stimulus with queue scoreboard and negedge monitors.
module tb_turf_udp_port_switch;
    import turf_udp_pkg::*;

    localparam int NP = 4;

    logic              clk = 0;
    logic              rst_n = 0;
    logic [63:0]       s_rxhdr_tdata = '0;
    logic              s_rxhdr_tvalid = 0;
    logic              s_rxhdr_tready;
    logic [15:0]       s_rxhdr_tdest = '0;
    logic [63:0]       s_rxdata_tdata = '0;
    logic [7:0]        s_rxdata_tkeep = '0;
    logic              s_rxdata_tlast = 0;
    logic              s_rxdata_tvalid = 0;
    logic              s_rxdata_tready;
    logic [NP*64-1:0]  m_rxhdr_tdata;
    logic [NP-1:0]     m_rxhdr_tvalid;
    logic [NP-1:0]     m_rxhdr_tready = '1;
    logic [NP*64-1:0]  m_rxdata_tdata;
    logic [NP*8-1:0]   m_rxdata_tkeep;
    logic [NP-1:0]     m_rxdata_tlast;
    logic [NP-1:0]     m_rxdata_tvalid;
    logic [NP-1:0]     m_rxdata_tready = '1;
    logic [NP*64-1:0]  s_txhdr_tdata = '0;
    logic [NP-1:0]     s_txhdr_tvalid = '0;
    logic [NP-1:0]     s_txhdr_tready;
    logic [NP*64-1:0]  s_txdata_tdata = '0;
    logic [NP*8-1:0]   s_txdata_tkeep = '0;
    logic [NP-1:0]     s_txdata_tlast = '0;
    logic [NP-1:0]     s_txdata_tvalid = '0;
    logic [NP-1:0]     s_txdata_tready;
    logic [63:0]       m_txhdr_tdata;
    logic              m_txhdr_tvalid;
    logic              m_txhdr_tready = 1;
    logic [15:0]       m_txhdr_tuser;
    logic [63:0]       m_txdata_tdata;
    logic [7:0]        m_txdata_tkeep;
    logic              m_txdata_tlast;
    logic              m_txdata_tvalid;
    logic              m_txdata_tready = 1;
    logic [31:0]       rx_drop_count;

    turf_udp_port_switch #(.NUM_PORTS(NP)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_rxhdr_tdata(s_rxhdr_tdata), .s_rxhdr_tvalid(s_rxhdr_tvalid),
        .s_rxhdr_tready(s_rxhdr_tready), .s_rxhdr_tdest(s_rxhdr_tdest),
        .s_rxdata_tdata(s_rxdata_tdata), .s_rxdata_tkeep(s_rxdata_tkeep),
        .s_rxdata_tlast(s_rxdata_tlast), .s_rxdata_tvalid(s_rxdata_tvalid),
        .s_rxdata_tready(s_rxdata_tready),
        .m_rxhdr_tdata(m_rxhdr_tdata), .m_rxhdr_tvalid(m_rxhdr_tvalid),
        .m_rxhdr_tready(m_rxhdr_tready),
        .m_rxdata_tdata(m_rxdata_tdata), .m_rxdata_tkeep(m_rxdata_tkeep),
        .m_rxdata_tlast(m_rxdata_tlast), .m_rxdata_tvalid(m_rxdata_tvalid),
        .m_rxdata_tready(m_rxdata_tready),
        .s_txhdr_tdata(s_txhdr_tdata), .s_txhdr_tvalid(s_txhdr_tvalid),
        .s_txhdr_tready(s_txhdr_tready),
        .s_txdata_tdata(s_txdata_tdata), .s_txdata_tkeep(s_txdata_tkeep),
        .s_txdata_tlast(s_txdata_tlast), .s_txdata_tvalid(s_txdata_tvalid),
        .s_txdata_tready(s_txdata_tready),
        .m_txhdr_tdata(m_txhdr_tdata), .m_txhdr_tvalid(m_txhdr_tvalid),
        .m_txhdr_tready(m_txhdr_tready), .m_txhdr_tuser(m_txhdr_tuser),
        .m_txdata_tdata(m_txdata_tdata), .m_txdata_tkeep(m_txdata_tkeep),
        .m_txdata_tlast(m_txdata_tlast), .m_txdata_tvalid(m_txdata_tvalid),
        .m_txdata_tready(m_txdata_tready),
        .rx_drop_count(rx_drop_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic bp = 0;

    logic [67:0] rxh_q[$];
    logic [76:0] rxd_q[$];
    logic [79:0] txh_q[$];
    logic [72:0] txd_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mkhdr(input logic [31:0] ip, input logic [15:0] port,
                                          input logic [15:0] len);
        return (64'(ip) << IP_LSB) | (64'(port) << PORT_LSB) | (64'(len) << LEN_LSB);
    endfunction

    // {last, keep, data}
    function automatic logic [72:0] beat(input logic [31:0] tag, input int b, input int nb);
        logic last;
        logic [7:0] keep;
        last = (b == nb - 1);
        keep = last ? 8'h07 : (8'hFF >> (b % 4));
        return {last, keep, tag, 32'(b)};
    endfunction

    function automatic logic rdy(input int kind, input int ch);
        case (kind)
            0: return s_rxhdr_tready;
            1: return s_rxdata_tready;
            2: return s_txhdr_tready[ch];
            default: return s_txdata_tready[ch];
        endcase
    endfunction

    task automatic wait_hs(input int kind, input int ch, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy(kind, ch) && n < 500);
        if (!rdy(kind, ch)) chk({name, "_timeout"}, 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic rx_send(input logic [15:0] dest, input logic [63:0] hdr, input logic [31:0] tag,
                           input int nb, input int ch);
        logic [72:0] d;
        logic [NP-1:0] exp_v;
        exp_v = ch >= 0 ? NP'(1 << ch) : '0;
        if (ch >= 0) rxh_q.push_back({4'(ch), hdr});
        for (int b = 0; b < nb; b++) if (ch >= 0) rxd_q.push_back({4'(ch), beat(tag, b, nb)});
        s_rxhdr_tdata  = hdr;
        s_rxhdr_tdest  = dest;
        s_rxhdr_tvalid = 1;
        wait_hs(0, 0, "rx_hdr");
        s_rxhdr_tvalid = 0;
        fork
            begin
                @(negedge clk);
                chk("rx_hdr_latency", m_rxhdr_tvalid, exp_v);
            end
        join_none
        for (int b = 0; b < nb; b++) begin
            d = beat(tag, b, nb);
            {s_rxdata_tlast, s_rxdata_tkeep, s_rxdata_tdata} = d;
            s_rxdata_tvalid = 1;
            wait_hs(1, 0, "rx_data");
        end
        s_rxdata_tvalid = 0;
        s_rxdata_tlast  = 0;
    endtask

    function automatic logic [63:0] tx_hdr_of(input int ch, input int p);
        return mkhdr(32'hC0A8_0000 + 32'(ch * 16 + p), 16'(5000 + ch), 16'(8 * (ch + 1)));
    endfunction

    function automatic logic [31:0] tx_tag(input int ch, input int p);
        return 32'h7700_0000 + 32'(ch * 256 + p);
    endfunction

    task automatic tx_src(input int ch);
        logic [72:0] d;
        for (int p = 0; p < 2; p++) begin
            s_txhdr_tdata[64*ch +: 64] = tx_hdr_of(ch, p);
            s_txhdr_tvalid[ch] = 1;
            wait_hs(2, ch, "tx_hdr");
            s_txhdr_tvalid[ch] = 0;
            for (int b = 0; b < ch + 1; b++) begin
                d = beat(tx_tag(ch, p), b, ch + 1);
                s_txdata_tlast[ch] = d[72];
                s_txdata_tkeep[8*ch +: 8] = d[71:64];
                s_txdata_tdata[64*ch +: 64] = d[63:0];
                s_txdata_tvalid[ch] = 1;
                wait_hs(3, ch, "tx_data");
            end
            s_txdata_tvalid[ch] = 0;
            s_txdata_tlast[ch] = 0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        m_rxdata_tready = '1;
        if (bp) m_rxdata_tready[1] = 1'($urandom_range(0, 1));
        m_txdata_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < NP; k++) begin
                if (m_rxhdr_tvalid[k] && m_rxhdr_tready[k]) begin
                    if (rxh_q.size() == 0) chk("rx_hdr_unexpected", 1, 0);
                    else chk("rx_hdr", {4'(k), m_rxhdr_tdata[64*k +: 64]}, rxh_q.pop_front());
                end
                if (m_rxdata_tvalid[k] && m_rxdata_tready[k]) begin
                    if (rxd_q.size() == 0) chk("rx_data_unexpected", 1, 0);
                    else chk("rx_data", {4'(k), m_rxdata_tlast[k], m_rxdata_tkeep[8*k +: 8],
                                         m_rxdata_tdata[64*k +: 64]}, rxd_q.pop_front());
                end
            end
            chk("rx_onehot", 128'($countones(m_rxdata_tvalid | m_rxhdr_tvalid) <= 1), 1);
            if (m_txhdr_tvalid && m_txhdr_tready) begin
                if (txh_q.size() == 0) chk("tx_hdr_unexpected", 1, 0);
                else chk("tx_hdr", {m_txhdr_tuser, m_txhdr_tdata}, txh_q.pop_front());
            end
            if (m_txdata_tvalid && m_txdata_tready) begin
                if (txd_q.size() == 0) chk("tx_data_unexpected", 1, 0);
                else chk("tx_data", {m_txdata_tlast, m_txdata_tkeep, m_txdata_tdata}, txd_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    int tx_order[6] = '{0, 1, 3, 0, 1, 3};
    logic [15:0] tx_sport[4] = '{16'd21600, 16'd21601, 16'd21602, 16'd21603};

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rxhdr_tready", s_rxhdr_tready, 0);
        chk("rst_rxdata_tready", s_rxdata_tready, 0);
        chk("rst_txhdr_tready", s_txhdr_tready, 0);
        chk("rst_m_rx_valid", {m_rxhdr_tvalid, m_rxdata_tvalid}, 0);
        chk("rst_m_tx_valid", {m_txhdr_tvalid, m_txdata_tvalid}, 0);
        chk("rst_tx_data_out", {m_txhdr_tuser, m_txhdr_tdata}, 0);
        chk("rst_drop_count", rx_drop_count, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        @(negedge clk);
        chk("idle_rxhdr_tready", s_rxhdr_tready, 1);
        @(posedge clk);
        #1;

        rx_send(16'd21602, mkhdr(32'h0A00_0001, 16'd4000, 16'd24), 32'hAAAA_0001, 3, 2);

        chk("drop_count_before", rx_drop_count, 0);
        rx_send(16'd9999, mkhdr(32'h0A00_0002, 16'd4001, 16'd40), 32'hBBBB_0002, 5, -1);
        @(negedge clk);
        chk("drop_count_after", rx_drop_count, 1);
        @(posedge clk);
        #1;
        rx_send(16'd21600, mkhdr(32'h0A00_0003, 16'd4002, 16'd16), 32'hCCCC_0003, 2, 0);

        bp = 1;
        rx_send(16'd21601, mkhdr(32'h0A00_0004, 16'd4003, 16'd64), 32'hDDDD_0004, 8, 1);
        rx_send(16'd21601, mkhdr(32'h0A00_0005, 16'd4004, 16'd8), 32'hDDDD_0005, 1, 1);
        bp = 0;

        // Truncated packet: only the header and first beat are ever delivered.
        rxh_q.push_back({4'd2, mkhdr(32'h0A00_0006, 16'd4005, 16'd32)});
        rxd_q.push_back({4'd2, beat(32'hEEEE_0006, 0, 4)});
        s_rxhdr_tdata  = mkhdr(32'h0A00_0006, 16'd4005, 16'd32);
        s_rxhdr_tdest  = 16'd21602;
        s_rxhdr_tvalid = 1;
        wait_hs(0, 0, "rst_pkt_hdr");
        s_rxhdr_tvalid = 0;
        {s_rxdata_tlast, s_rxdata_tkeep, s_rxdata_tdata} = beat(32'hEEEE_0006, 0, 4);
        s_rxdata_tvalid = 1;
        wait_hs(1, 0, "rst_pkt_beat0");
        {s_rxdata_tlast, s_rxdata_tkeep, s_rxdata_tdata} = beat(32'hEEEE_0006, 1, 4);
        rst_n = 0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_m_rx_valid", {m_rxhdr_tvalid, m_rxdata_tvalid}, 0);
        chk("midrst_m_rx_data", {m_rxdata_tdata, m_rxdata_tkeep, m_rxdata_tlast}, 0);
        chk("midrst_readies", {s_rxhdr_tready, s_rxdata_tready, s_txhdr_tready, s_txdata_tready}, 0);
        chk("midrst_drop_count", rx_drop_count, 0);
        @(posedge clk);
        #1;
        s_rxdata_tvalid = 0;
        rst_n = 1;
        rx_send(16'd21600, mkhdr(32'h0A00_0007, 16'd4006, 16'd24), 32'hFFFF_0007, 3, 0);

        force dut.rx_drop_count = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.rx_drop_count;
        @(negedge clk);
        chk("sat_preload", rx_drop_count, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        rx_send(16'd1234, mkhdr(32'h0A00_0008, 16'd4007, 16'd16), 32'h1111_0008, 2, -1);
        @(negedge clk);
        chk("sat_hold", rx_drop_count, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            txh_q.push_back({tx_sport[tx_order[i]], tx_hdr_of(tx_order[i], i / 3)});
            for (int b = 0; b < tx_order[i] + 1; b++)
                txd_q.push_back(beat(tx_tag(tx_order[i], i / 3), b, tx_order[i] + 1));
        end
        bp = 1;
        fork
            tx_src(0);
            tx_src(1);
            tx_src(3);
        join
        bp = 0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rxh_q_empty", rxh_q.size(), 0);
        chk("rxd_q_empty", rxd_q.size(), 0);
        chk("txh_q_empty", txh_q.size(), 0);
        chk("txd_q_empty", txd_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
